// File: rtl/axi_master_bridge.sv
// axi_master_bridge: turns the CPU's one-request-at-a-time memory port into single-beat AXI4 reads/writes.
// Optional macro AXI_MASTER_ERR_EN adds cpu_err, flagging a non-OKAY RRESP/BRESP on completion.
module axi_master_bridge #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MST_ID = 0,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [STRB_W-1:0] cpu_wstrb,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
`ifdef AXI_MASTER_ERR_EN
    ,
    output logic              cpu_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_arvalid, w_arvalid_nxt;
    logic              r_rready, w_rready_nxt;
    logic              r_awvalid, w_awvalid_nxt;
    logic              r_wvalid, w_wvalid_nxt;
    logic              r_bready, w_bready_nxt;
    logic              r_aw_ok, w_aw_ok_nxt;
    logic              r_w_ok, w_w_ok_nxt;
    logic              r_done, w_done_nxt;
    logic              w_accept, w_rd_cap, w_resp_err;
    logic              w_aw_hs, w_w_hs;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [STRB_W-1:0] r_wstrb;

    assign w_aw_hs = r_awvalid && AWREADY;
    assign w_w_hs  = r_wvalid && WREADY;

    // Next-state and next-handshake-flag decode for the transaction sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_aw_ok_nxt   = r_aw_ok;
        w_w_ok_nxt    = r_w_ok;
        w_done_nxt    = 1'b0;
        w_accept      = 1'b0;
        w_rd_cap      = 1'b0;
        w_resp_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req && !r_done) begin
                    w_accept = 1'b1;
                    if (cpu_we) begin
                        w_state_nxt   = S_WREQ;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_RADDR;
                        w_arvalid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RADDR: begin
                if (r_arvalid && ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RDATA;
                end else begin
                    w_state_nxt = S_RADDR;
                end
            end
            S_RDATA: begin
                // Non-last beats are drained and dropped; only the RLAST beat completes
                if (RVALID && r_rready && RLAST) begin
                    w_rd_cap     = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_rready_nxt = 1'b0;
                    w_resp_err   = (RRESP != 2'b00);
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_state_nxt = S_RDATA;
                end
            end
            S_WREQ: begin
                if ((r_aw_ok || w_aw_hs) && (r_w_ok || w_w_hs)) begin
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b0;
                    w_aw_ok_nxt   = 1'b0;
                    w_w_ok_nxt    = 1'b0;
                    w_bready_nxt  = 1'b1;
                    w_state_nxt   = S_WRESP;
                end else begin
                    w_awvalid_nxt = r_awvalid && !w_aw_hs;
                    w_wvalid_nxt  = r_wvalid && !w_w_hs;
                    w_aw_ok_nxt   = r_aw_ok || w_aw_hs;
                    w_w_ok_nxt    = r_w_ok || w_w_hs;
                end
            end
            S_WRESP: begin
                if (BVALID && r_bready) begin
                    w_bready_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_resp_err   = (BRESP != 2'b00);
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_state_nxt = S_WRESP;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
                w_aw_ok_nxt   = 1'b0;
                w_w_ok_nxt    = 1'b0;
            end
        endcase
    end

    // Sequencer state, channel VALID/READY and completion pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_w_ok    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_aw_ok   <= w_aw_ok_nxt;
            r_w_ok    <= w_w_ok_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Request payload latched at accept keeps AXI address/data stable under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
                r_wstrb <= cpu_wstrb;
            end
            if (w_rd_cap) begin
                r_rdata <= RDATA;
            end
        end
    end

`ifdef AXI_MASTER_ERR_EN
    logic r_err;
    logic w_unused_id;

    // Error flag rises with cpu_done and is cleared by the next accepted request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_done_nxt) begin
            r_err <= w_resp_err;
        end
    end

    assign cpu_err     = r_err;
    assign w_unused_id = ^{RID, BID};
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{RID, BID, RRESP, BRESP, w_resp_err};
`endif

    assign cpu_rdata = r_rdata;
    assign cpu_done  = r_done;
    assign cpu_busy  = (r_state != S_IDLE);
    assign ARID      = ID_W'(MST_ID);
    assign ARADDR    = r_addr;
    assign ARLEN     = 4'd0;
    assign ARSIZE    = 3'b010;
    assign ARBURST   = 2'b01;
    assign ARVALID   = r_arvalid;
    assign RREADY    = r_rready;
    assign AWID      = ID_W'(MST_ID);
    assign AWADDR    = r_addr;
    assign AWLEN     = 4'd0;
    assign AWSIZE    = 3'b010;
    assign AWBURST   = 2'b01;
    assign AWVALID   = r_awvalid;
    assign WDATA     = r_wdata;
    assign WSTRB     = r_wstrb;
    assign WLAST     = 1'b1;
    assign WVALID    = r_wvalid;
    assign BREADY    = r_bready;

endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Converts the CPU core's simple one-request-at-a-time memory port into single-beat AXI4 master transactions.
- Sits inside the CPU wrapper, one instance per master port: M0 for instruction fetch, M1 for data.
- Directly feeds the AXI interconnect's master-side AR/R/AW/W/B channels.
- Handles one outstanding transaction at a time; holds AXI outputs stable under backpressure.

Parameters:
- ID_W, 4: AXI ID width.
- ADDR_W, 32: address width.
- DATA_W, 32: data width. STRB_W = DATA_W/8.
- MST_ID, 0: constant ID driven on ARID/AWID.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; held high until cpu_done.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address, word aligned.
- cpu_wdata  in  DATA_W  write data.
- cpu_wstrb  in  STRB_W  byte enables.
- cpu_rdata  out  DATA_W  read data; valid while cpu_done is high.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high when state is not IDLE.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  ID_W/ADDR_W/4/3/2/1  read address channel.
- ARREADY  in  1  read address ready.
- RID/RDATA/RRESP/RLAST/RVALID  in  ID_W/DATA_W/2/1/1  read data channel.
- RREADY  out  1  read data ready.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ID_W/ADDR_W/4/3/2/1  write address channel.
- AWREADY  in  1  write address ready.
- WDATA/WSTRB/WLAST/WVALID  out  DATA_W/STRB_W/1/1  write data channel.
- WREADY  in  1  write data ready.
- BID/BRESP/BVALID  in  ID_W/2/1  write response channel.
- BREADY  out  1  write response ready.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all VALID/READY outputs 0; cpu_done=0; cpu_rdata=0; internal aw_ok/w_ok flags 0. Reset mid-transaction abandons it; no completion is reported.
- Constant outputs: ARLEN/AWLEN=0, ARSIZE/AWSIZE=3'b010, ARBURST/AWBURST=2'b01 (INCR), WLAST=1, ARID/AWID=MST_ID.
- Accept: in IDLE with cpu_req=1 and cpu_done=0, latch addr/wdata/wstrb/we into registers. All AXI address/data outputs come from these registers, so they stay stable while VALID is high and READY is low.
- States: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE -> RADDR (we=0): ARVALID=1 from the next cycle.
- RADDR: on ARVALID && ARREADY, drop ARVALID and go to RDATA with RREADY=1.
- RDATA: on RVALID && RREADY && RLAST, register RDATA into cpu_rdata, pulse cpu_done next cycle, go to IDLE. A beat with RLAST=0 is consumed and the state is kept.
- IDLE -> WREQ (we=1): AWVALID=1 and WVALID=1 together.
  - Each channel drops its VALID independently after its own handshake and sets aw_ok or w_ok.
  - Both handshakes in the same cycle is legal.
  - When both flags are set (including the same cycle), go to WRESP with BREADY=1 and clear the flags.
- WRESP: on BVALID && BREADY, pulse cpu_done next cycle and go to IDLE.
- Minimum latency from accept to cpu_done with zero-wait slaves: read 3 cycles, write 3 cycles.
- cpu_done blocks acceptance in its own cycle. Back-to-back requests are therefore spaced by at least one idle cycle.
- RRESP/BRESP are ignored unless the optional feature is enabled. RID/BID are not checked.
- No VALID is deasserted before its handshake completes.

Optional Feature:
- Macro AXI_MASTER_ERR_EN.
- Defined: adds output cpu_err (1 bit, reset 0). cpu_err is registered high together with cpu_done when the completing RRESP or BRESP is not 2'b00. It clears on the next accepted request.
- Undefined: the port is absent and response codes are ignored.

Test Plan:
- Read, zero-wait slave: addr 0x0000_0010, RDATA 0xDEAD_BEEF -> ARADDR=0x10, ARLEN=0, ARSIZE=2; cpu_done 3 cycles after accept; cpu_rdata=0xDEADBEEF.
- Read, ARREADY held low 5 cycles -> ARVALID and ARADDR stable for all 5 cycles; exactly one AR handshake; one cpu_done.
- Write addr 0x0001_0004, wdata 0x1234_5678, wstrb 4'b0011; WREADY arrives 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID holds; BREADY only after both handshakes; single cpu_done after B.
- AWREADY and WREADY both high in the accept+1 cycle -> both handshakes in one cycle; WRESP entered next cycle.
- rst pulled low while in RDATA -> all VALID/READY outputs 0 immediately; no cpu_done; a new read after reset completes normally.
- With AXI_MASTER_ERR_EN: BRESP=2'b10 -> cpu_err=1 with cpu_done; next read with RRESP=0 -> cpu_err=0.
